bcd_scan_display: RTL and testbench

- Downstream consumer of the 4-digit BCD counter stage. Takes the packed digits BCD3..BCD0 and drives a common-anode 4-digit 7-segment display by time-multiplexing.
- Per-frame shadow capture prevents digit tearing.
- Includes leading-zero blanking and overflow rendering: code 4'hF is the counter's overflow marker and is shown as a dash.

---
 rtl/bcd_scan_display.sv | 170 +++++++++++++++++
 tb/tb_bcd_scan_display.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
// -----------------------------------------------------------------------------
// bcd_scan_display
//
// Drives a common-anode 4-digit 7-segment display from the packed BCD digits
// of the counter stage. The display is time-multiplexed: each digit is lit for
// REFRESH_DIV clock cycles, so one full frame takes 4*REFRESH_DIV cycles.
//
// All four digits are copied into a shadow register at once, at the start of
// each frame. This keeps a frame from showing a mix of old and new digits.
// Leading zeros on digits 3..1 can be blanked. Code 4'hF is the counter's
// overflow marker and is shown as a dash. Codes 4'hA..4'hE show nothing.
//
// Ports
//   Clk        system clock
//   Reset      synchronous, active-high
//   BCD0..BCD3 ones / tens / hundreds / thousands digit (0-9, 4'hF overflow)
//   Blank      forces all anodes off while high; scanning keeps running
//   An[3:0]    anode enables, active-low, An[i] = digit i (registered)
//   Seg[6:0]   segments {g,f,e,d,c,b,a}, active-low (registered)
//   Dp         decimal point, active-low, always off
//   FrameTick  one-cycle pulse in the cycle after each shadow capture
//
// Scan index (idx_q):
//   idx | meaning
//   0   | ones digit lit, An = 4'b1110
//   1   | tens digit lit, An = 4'b1101
//   2   | hundreds digit lit, An = 4'b1011
//   3   | thousands digit lit, An = 4'b0111 (frame ends at its terminal count)
// -----------------------------------------------------------------------------
module bcd_scan_display #(
    parameter int unsigned REFRESH_DIV = 1024,
    parameter int unsigned LZ_BLANK    = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] BCD0,
    input  logic [3:0] BCD1,
    input  logic [3:0] BCD2,
    input  logic [3:0] BCD3,
    input  logic       Blank,
    output logic [3:0] An,
    output logic [6:0] Seg,
    output logic       Dp,
    output logic       FrameTick
);

    localparam int unsigned        PRESC_W    = $clog2(REFRESH_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    // Scan timing and frame state
    logic [PRESC_W-1:0] prescaler_q, prescaler_d;
    logic [1:0]         idx_q, idx_d;
    logic [15:0]        shadow_q, shadow_d;
    logic               valid_q, valid_d;

    // Registered display outputs
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               frame_tick_q, frame_tick_d;

    logic               presc_tc;
    logic               capture;

    // Leading-zero blanking, evaluated on the shadow copy
    logic               lz_en;
    logic               blank3, blank2, blank1;
    logic [3:0]         digit_cur;
    logic               digit_blank;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hF:    seg = SEG_DASH;
            default: seg = SEG_OFF;   // A..E are illegal: show nothing
        endcase
        return seg;
    endfunction

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            prescaler_q  <= '0;
            idx_q        <= 2'd0;
            shadow_q     <= 16'h0000;
            valid_q      <= 1'b0;
            an_q         <= 4'b1111;
            seg_q        <= SEG_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            prescaler_q  <= prescaler_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            valid_q      <= valid_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        presc_tc    = (prescaler_q == PRESC_LAST);

        // The first edge after reset loads the shadow (valid_q is still 0).
        // After that, loading happens only at the frame boundary, which is the
        // same edge where idx wraps from 3 to 0.
        capture     = !valid_q || (presc_tc && (idx_q == 2'd3));

        prescaler_d = presc_tc ? '0 : prescaler_q + PRESC_W'(1);
        idx_d       = presc_tc ? idx_q + 2'd1 : idx_q;
        valid_d     = 1'b1;
        shadow_d    = capture ? {BCD3, BCD2, BCD1, BCD0} : shadow_q;
    end

    // -------------------------------------------------------------------------
    // Output logic (registered next cycle)
    // -------------------------------------------------------------------------
    assign lz_en  = (LZ_BLANK != 0);
    assign blank3 = lz_en && (shadow_q[15:12] == 4'h0);
    assign blank2 = blank3 && (shadow_q[11:8] == 4'h0);
    assign blank1 = blank2 && (shadow_q[7:4]  == 4'h0);

    always_comb begin
        digit_cur   = shadow_q[3:0];
        digit_blank = 1'b0;
        case (idx_q)
            2'd0: begin digit_cur = shadow_q[3:0];   digit_blank = 1'b0;   end
            2'd1: begin digit_cur = shadow_q[7:4];   digit_blank = blank1; end
            2'd2: begin digit_cur = shadow_q[11:8];  digit_blank = blank2; end
            2'd3: begin digit_cur = shadow_q[15:12]; digit_blank = blank3; end
            default: begin digit_cur = shadow_q[3:0]; digit_blank = 1'b0;  end
        endcase

        // A blanked leading zero keeps its anode driven, so every digit gets
        // the same on-time and the brightness stays uniform.
        an_d  = 4'b1111;
        seg_d = SEG_OFF;
        if (valid_q && !Blank) begin
            an_d = ~(4'b0001 << idx_q);
            if (!digit_blank) begin
                seg_d = seg_decode(digit_cur);
            end
        end

        frame_tick_d = capture;
    end

    assign An        = an_q;
    assign Seg       = seg_q;
    assign Dp        = 1'b1;
    assign FrameTick = frame_tick_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// -----------------------------------------------------------------------------
// tb_bcd_scan_display
//
// Two instances share the clock: u_dut_a (LZ_BLANK=1) and u_dut_b (LZ_BLANK=0),
// both with REFRESH_DIV=4. The stimulus pushes one expected frame into exp_q
// for every shadow capture it sets up. The monitor pops an entry on each
// FrameTick and checks the An/Seg scan over the next 16 cycles. The monitor
// also checks the spacing between FrameTick pulses.
// -----------------------------------------------------------------------------
module tb_bcd_scan_display;

    localparam int unsigned RDIV  = 4;
    localparam int          FRAME = 4 * RDIV;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] BL = 7'b1111111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic [3:0] a_bcd0, a_bcd1, a_bcd2, a_bcd3;
    logic [3:0] b_bcd0, b_bcd1, b_bcd2, b_bcd3;
    logic       a_blank, b_blank;
    logic [3:0] a_an, b_an;
    logic [6:0] a_seg, b_seg;
    logic       a_dp, b_dp, a_ft, b_ft;

    bcd_scan_display #(.REFRESH_DIV(RDIV), .LZ_BLANK(1)) u_dut_a (
        .Clk(clk), .Reset(rst_a),
        .BCD0(a_bcd0), .BCD1(a_bcd1), .BCD2(a_bcd2), .BCD3(a_bcd3),
        .Blank(a_blank), .An(a_an), .Seg(a_seg), .Dp(a_dp), .FrameTick(a_ft)
    );

    bcd_scan_display #(.REFRESH_DIV(RDIV), .LZ_BLANK(0)) u_dut_b (
        .Clk(clk), .Reset(rst_b),
        .BCD0(b_bcd0), .BCD1(b_bcd1), .BCD2(b_bcd2), .BCD3(b_bcd3),
        .Blank(b_blank), .An(b_an), .Seg(b_seg), .Dp(b_dp), .FrameTick(b_ft)
    );

    // Monitor view: sel picks which instance is under observation
    logic       sel;
    logic       m_rst, m_ft;
    logic [3:0] m_an;
    logic [6:0] m_seg;
    assign m_rst = sel ? rst_b : rst_a;
    assign m_ft  = sel ? b_ft  : a_ft;
    assign m_an  = sel ? b_an  : a_an;
    assign m_seg = sel ? b_seg : a_seg;

    typedef struct packed {
        logic [27:0] segs;   // {seg3, seg2, seg1, seg0}
        logic [15:0] dark;   // bit k set: scan cycle k expected fully off
    } frame_t;

    frame_t exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_frame(input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0,
                              input logic [15:0] dark);
        frame_t f;
        f.segs = {s3, s2, s1, s0};
        f.dark = dark;
        exp_q.push_back(f);
    endtask

    task automatic set_a(input logic [15:0] v);
        {a_bcd3, a_bcd2, a_bcd1, a_bcd0} = v;
    endtask

    task automatic wait_ft();
        for (int n = 0; n < 3 * FRAME; n++) begin
            @(negedge clk);
            if (m_ft === 1'b1) return;
        end
        total++;
        bad++;
        $display("FAIL frame_tick_timeout: got no pulse, required one within %0d cycles", 3 * FRAME);
    endtask

    // -------------------------------------------------------------------------
    // Monitor / scoreboard
    // -------------------------------------------------------------------------
    initial begin : monitor
        frame_t     cur;
        bit         in_frame;
        int         k, gap, ft_n, d;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        cur      = '0;
        in_frame = 1'b0;
        k        = 0;
        gap      = 0;
        ft_n     = 0;
        forever begin
            @(negedge clk);
            if (m_rst === 1'b1) begin
                in_frame = 1'b0;
                gap      = 0;
                ft_n     = 0;
            end else begin
                gap++;
                if (in_frame) begin
                    d = k / RDIV;
                    if (cur.dark[k]) begin
                        e_an  = 4'b1111;
                        e_seg = BL;
                    end else begin
                        e_an  = ~(4'b0001 << d);
                        e_seg = cur.segs[d*7 +: 7];
                    end
                    check($sformatf("scan_an k=%0d", k), m_an, e_an);
                    check($sformatf("scan_seg k=%0d", k), m_seg, e_seg);
                    k++;
                    if (k == FRAME) in_frame = 1'b0;
                end
                if (m_ft === 1'b1) begin
                    // The first frame after reset is one cycle short because the
                    // prescaler advances on the capture edge itself.
                    if (ft_n >= 2) check("frame_tick_period", gap, FRAME);
                    ft_n++;
                    gap = 0;
                    if (exp_q.size() > 0) begin
                        cur      = exp_q.pop_front();
                        in_frame = 1'b1;
                        k        = 0;
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    logic [15:0] tbl_bcd [9];
    logic [27:0] tbl_seg [9];

    initial begin : stim
        tbl_bcd[0] = 16'h0001; tbl_seg[0] = {BL, BL, BL, S1};
        tbl_bcd[1] = 16'h1203; tbl_seg[1] = {S1, S2, S0, S3};
        tbl_bcd[2] = 16'hFFFF; tbl_seg[2] = {SD, SD, SD, SD};
        tbl_bcd[3] = 16'h4789; tbl_seg[3] = {S4, S7, S8, S9};
        tbl_bcd[4] = 16'hABC0; tbl_seg[4] = {BL, BL, BL, S0};
        tbl_bcd[5] = 16'hDE00; tbl_seg[5] = {BL, BL, S0, S0};
        tbl_bcd[6] = 16'h0050; tbl_seg[6] = {BL, BL, S5, S0};
        tbl_bcd[7] = 16'hF000; tbl_seg[7] = {SD, S0, S0, S0};
        tbl_bcd[8] = 16'h0000; tbl_seg[8] = {BL, BL, BL, S0};

        sel     = 1'b0;
        rst_a   = 1'b1;
        rst_b   = 1'b1;
        a_blank = 1'b0;
        b_blank = 1'b0;
        set_a(16'h0001);
        {b_bcd3, b_bcd2, b_bcd1, b_bcd0} = 16'h0000;

        // Reset state of instance A
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("a_reset_an", a_an, 4'b1111);
        check("a_reset_seg", a_seg, BL);
        check("a_reset_dp", a_dp, 1'b1);
        check("a_reset_ft", a_ft, 1'b0);
        rst_a = 1'b0;

        // First cycle after release is dark, with the capture pulse
        @(negedge clk);
        check("a_first_an", a_an, 4'b1111);
        check("a_first_ft", a_ft, 1'b1);
        @(negedge clk);
        check("a_digit0_an", a_an, 4'b1110);
        check("a_digit0_seg", a_seg, S1);

        // Directed frames: set digits just after a FrameTick. They are
        // captured at the next frame boundary.
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin
                wait_ft();
                @(negedge clk);
            end
            set_a(tbl_bcd[i]);
            push_frame(tbl_seg[i][27:21], tbl_seg[i][20:14], tbl_seg[i][13:7], tbl_seg[i][6:0], 16'h0000);
        end

        // A change in the middle of a frame must not tear the displayed frame
        wait_ft();
        @(negedge clk);
        set_a(16'h0005);
        push_frame(BL, BL, BL, S5, 16'h0000);
        wait_ft();
        repeat (6) @(negedge clk);
        check("a_idx1_before_change", a_an, 4'b1101);
        a_bcd0 = 4'h6;
        push_frame(BL, BL, BL, S6, 16'h0000);

        // Blank for 10 cycles, starting 3 cycles into a frame: dark on scan
        // cycles 3..12
        wait_ft();
        @(negedge clk);
        push_frame(BL, BL, BL, S6, 16'h1FF8);
        wait_ft();
        repeat (3) @(negedge clk);
        a_blank = 1'b1;
        repeat (10) @(negedge clk);
        a_blank = 1'b0;
        wait_ft();

        // Instance B: no leading-zero blanking, then a mid-frame reset
        @(negedge clk);
        sel = 1'b1;
        repeat (2) @(negedge clk);
        check("b_reset_an", b_an, 4'b1111);
        check("b_reset_seg", b_seg, BL);
        rst_b = 1'b0;
        wait_ft();
        @(negedge clk);
        push_frame(S0, S0, S0, S0, 16'h0000);
        wait_ft();
        repeat (9) @(negedge clk);
        check("b_an_at_idx2", b_an, 4'b1011);
        rst_b = 1'b1;
        @(negedge clk);
        check("b_midreset_an", b_an, 4'b1111);
        check("b_midreset_seg", b_seg, BL);
        check("b_midreset_dp", b_dp, 1'b1);
        check("b_midreset_ft", b_ft, 1'b0);
        rst_b = 1'b0;
        @(negedge clk);
        check("b_dark_after_reset_an", b_an, 4'b1111);
        check("b_dark_after_reset_ft", b_ft, 1'b1);
        @(negedge clk);
        check("b_restart_idx0_an", b_an, 4'b1110);
        check("b_restart_idx0_seg", b_seg, S0);
        push_frame(S0, S0, S0, S0, 16'h0000);
        wait_ft();
        wait_ft();
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
